tripod_gait_sequencer: RTL
==========================

// Module: tripod_gait_sequencer
// PURPOSE
// Downstream consumer of the homing/wait enable. While enable is high, steps the hexapod
// through a 6-phase tripod gait: leg group A = L1, R2, L3; group B = R1, L2, R3.
// Drives registered hip/knee servo position codes to the servo PWM stage.
// When enable drops, finishes safely (knees down) and parks in HOME.
// PARAMETERS
// STEP_DIV    8'd1    step_tick pulses per gait phase; 0 is treated as 1
// HIP_CENTER  8'd128  hip neutral position code
// HIP_SWING   8'd32   hip offset; fwd = CENTER+SWING, back = CENTER-SWING, each clamped to 0..255
// KNEE_DOWN   8'd100  knee stance position code
// KNEE_UP     8'd160  knee lifted position code
// PORTS
// clk         in   1  system clock
// rst         in   1  synchronous, active-high reset
// enable      in   1  gait enable, level (homing enable output)
// step_tick   in   1  1-clk pulse, phase timebase (heartrate output)
// hip_a       out  8  group A hip position code
// knee_a      out  8  group A knee position code
// hip_b       out  8  group B hip position code
// knee_b      out  8  group B knee position code
// phase       out  3  current state code
// homed       out  1  high when state == HOME
// cycle_done  out  1  1-clk pulse on the B_DOWN -> A_UP transition
// BEHAVIOUR
// - One clock (clk); reset is synchronous and active-high (rst). All flops are reset by rst only.
// - Reset values: state = HOME (0); tick_cnt = 0; cycle_done = 0; homed = 1.
//   Outputs hip_a = hip_b = HIP_CENTER, knee_a = knee_b = KNEE_DOWN.
// - Divider: 8-bit tick_cnt counts step_tick pulses.
//   phase_adv = step_tick && tick_cnt == STEP_DIV-1; tick_cnt then wraps to 0.
//   The divider free-runs regardless of enable. step_tick with rst asserted is ignored.
// - The state changes only on phase_adv. Codes: HOME=0, A_UP=1, A_FWD=2, A_DOWN=3,
//   B_UP=4, B_FWD=5, B_DOWN=6, PARK=7.
// - enable = 1 at phase_adv:
//   HOME->A_UP->A_FWD->A_DOWN->B_UP->B_FWD->B_DOWN->A_UP (wrap).
//   PARK always -> HOME, even if enable has returned.
// - enable = 0 at phase_adv:
//   A_UP, A_FWD, B_UP, B_FWD -> PARK; A_DOWN, B_DOWN -> HOME; PARK -> HOME; HOME holds.
// - enable is sampled only at phase_adv. Toggles between advances have no effect.
// - Position table (F = fwd, K = back, C = center, U = KNEE_UP, D = KNEE_DOWN),
//   listed as hip_a/knee_a/hip_b/knee_b:
//   HOME   C/D/C/D
//   A_UP   K/U/F/D
//   A_FWD  F/U/K/D
//   A_DOWN F/D/K/D
//   B_UP   F/D/K/U
//   B_FWD  K/D/F/U
//   B_DOWN K/D/F/D
//   PARK   holds the previous hips; both knees D.
// - Outputs, phase and homed are registered. They change in the same clock edge as state,
//   i.e. 1 clk after the phase_adv cycle. There is no combinational path from inputs to outputs.
// - Invariant: knee_a and knee_b are never both KNEE_UP (the verifier asserts this every cycle).
// - Clamp arithmetic is done in 9 bits: F = min(C+S, 255), K = max(C-S, 0).
// - cycle_done is high for exactly one clk, aligned with the A_UP outputs.
// - rst mid-gait: on the next edge all outputs return to their reset values, with no PARK step.
// TESTING
// 1. rst high 2 clk, enable=0, ticks -> phase=0, homed=1, hips=128, knees=100; ticks keep HOME.
// 2. STEP_DIV=1, enable=1, 7 ticks -> phase 1,2,3,4,5,6,1; at the 2nd tick
//    hip_a=160, knee_a=160, hip_b=96, knee_b=100; cycle_done pulses once, at the 7th tick.
// 3. In A_FWD (phase=2), drop enable, tick -> phase=7, knees 100/100, hips 160/96;
//    next tick -> phase=0, hips 128/128.
// 4. STEP_DIV=3, enable=1 -> the state advances only on every 3rd tick;
//    enable pulsed low between ticks -> no effect.
// 5. HIP_CENTER=240, HIP_SWING=32 -> fwd clamps to 255, back = 208.
//    HIP_CENTER=10 -> back clamps to 0.
// 6. rst asserted in B_UP coincident with step_tick -> next clk phase=0, all outputs at reset
//    values, tick_cnt=0.

Source files
------------

// File: rtl/tripod_gait_sequencer_if.sv
// Purpose: bundles the gait sequencer's control inputs and servo/status outputs.
// Signals:
//   enable      gait enable level from the homing stage
//   step_tick   1-clk phase timebase pulse
//   hip_a/knee_a, hip_b/knee_b  servo position codes for leg groups A and B
//   phase       current gait state code
//   homed       high while parked in HOME
//   cycle_done  1-clk pulse when a full gait cycle wraps back to A_UP
// Modports: master drives the inputs and observes the outputs; slave is the sequencer.
interface tripod_gait_sequencer_if;
  logic       enable;
  logic       step_tick;
  logic [7:0] hip_a;
  logic [7:0] knee_a;
  logic [7:0] hip_b;
  logic [7:0] knee_b;
  logic [2:0] phase;
  logic       homed;
  logic       cycle_done;

  modport master (
    output enable, step_tick,
    input  hip_a, knee_a, hip_b, knee_b, phase, homed, cycle_done
  );

  modport slave (
    input  enable, step_tick,
    output hip_a, knee_a, hip_b, knee_b, phase, homed, cycle_done
  );
endinterface

// File: rtl/tripod_gait_sequencer.sv
// Purpose: steps a hexapod through a 6-phase tripod gait while enabled
// (group A = L1,R2,L3; group B = R1,L2,R3) and drives registered hip/knee
// position codes. When enable drops the gait finishes with knees down and
// parks in HOME.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   gait  slave side of tripod_gait_sequencer_if (enable, step_tick in;
//         hip/knee codes, phase, homed, cycle_done out)
module tripod_gait_sequencer #(
  parameter logic [7:0] STEP_DIV   = 8'd1,
  parameter logic [7:0] HIP_CENTER = 8'd128,
  parameter logic [7:0] HIP_SWING  = 8'd32,
  parameter logic [7:0] KNEE_DOWN  = 8'd100,
  parameter logic [7:0] KNEE_UP    = 8'd160
) (
  input  logic                         clk,
  input  logic                         rst,
  tripod_gait_sequencer_if.slave       gait
);

  typedef enum logic [2:0] {
    HOME   = 3'd0,
    A_UP   = 3'd1,
    A_FWD  = 3'd2,
    A_DOWN = 3'd3,
    B_UP   = 3'd4,
    B_FWD  = 3'd5,
    B_DOWN = 3'd6,
    PARK   = 3'd7
  } state_t;

  // Saturating add in 9 bits: carry out means the result exceeded 255.
  function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [7:0] s);
    logic [8:0] sum;
    sum = {1'b0, c} + {1'b0, s};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Saturating subtract in 9 bits signed: -255..255 fits, negative clamps to 0.
  function automatic logic [7:0] sat_sub(input logic [7:0] c, input logic [7:0] s);
    logic signed [8:0] diff;
    diff = $signed({1'b0, c}) - $signed({1'b0, s});
    return (diff < 0) ? 8'h00 : diff[7:0];
  endfunction

  // Transition taken at a phase advance. Phases with a leg group lifted go
  // through PARK so the knees come down before HOME; PARK always exits to HOME.
  function automatic state_t next_state(input state_t cur, input logic en);
    state_t nxt;
    nxt = HOME;
    if (en) begin
      case (cur)
        HOME:    nxt = A_UP;
        A_UP:    nxt = A_FWD;
        A_FWD:   nxt = A_DOWN;
        A_DOWN:  nxt = B_UP;
        B_UP:    nxt = B_FWD;
        B_FWD:   nxt = B_DOWN;
        B_DOWN:  nxt = A_UP;
        default: nxt = HOME;
      endcase
    end else begin
      case (cur)
        A_UP, A_FWD, B_UP, B_FWD: nxt = PARK;
        default:                  nxt = HOME;
      endcase
    end
    return nxt;
  endfunction

  localparam logic [7:0] HIP_FWD  = sat_add(HIP_CENTER, HIP_SWING);
  localparam logic [7:0] HIP_BACK = sat_sub(HIP_CENTER, HIP_SWING);
  // A divide of 0 behaves as 1, so the terminal count is 0 in both cases.
  localparam logic [7:0] DIV_LAST = (STEP_DIV == 8'd0) ? 8'd0 : STEP_DIV - 8'd1;

  state_t     state;
  logic [7:0] tick_cnt;
  logic [7:0] hip_a;
  logic [7:0] knee_a;
  logic [7:0] hip_b;
  logic [7:0] knee_b;
  logic       homed;
  logic       cycle_done;
  logic       phase_adv;
  state_t     nxt;

  assign phase_adv = gait.step_tick && (tick_cnt == DIV_LAST);
  assign nxt       = next_state(state, gait.enable);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HOME;
      tick_cnt   <= 8'd0;
      hip_a      <= HIP_CENTER;
      knee_a     <= KNEE_DOWN;
      hip_b      <= HIP_CENTER;
      knee_b     <= KNEE_DOWN;
      homed      <= 1'b1;
      cycle_done <= 1'b0;
    end else begin
      // Divider runs independently of enable.
      if (gait.step_tick) begin
        tick_cnt <= (tick_cnt == DIV_LAST) ? 8'd0 : tick_cnt + 8'd1;
      end
      cycle_done <= 1'b0;
      if (phase_adv) begin
        state      <= nxt;
        homed      <= (nxt == HOME);
        cycle_done <= (state == B_DOWN) && (nxt == A_UP);
        // Outputs are decoded from the state being entered so they update
        // on the same edge as phase.
        case (nxt)
          HOME: begin
            hip_a <= HIP_CENTER; knee_a <= KNEE_DOWN;
            hip_b <= HIP_CENTER; knee_b <= KNEE_DOWN;
          end
          A_UP: begin
            hip_a <= HIP_BACK;   knee_a <= KNEE_UP;
            hip_b <= HIP_FWD;    knee_b <= KNEE_DOWN;
          end
          A_FWD: begin
            hip_a <= HIP_FWD;    knee_a <= KNEE_UP;
            hip_b <= HIP_BACK;   knee_b <= KNEE_DOWN;
          end
          A_DOWN: begin
            hip_a <= HIP_FWD;    knee_a <= KNEE_DOWN;
            hip_b <= HIP_BACK;   knee_b <= KNEE_DOWN;
          end
          B_UP: begin
            hip_a <= HIP_FWD;    knee_a <= KNEE_DOWN;
            hip_b <= HIP_BACK;   knee_b <= KNEE_UP;
          end
          B_FWD: begin
            hip_a <= HIP_BACK;   knee_a <= KNEE_DOWN;
            hip_b <= HIP_FWD;    knee_b <= KNEE_UP;
          end
          B_DOWN: begin
            hip_a <= HIP_BACK;   knee_a <= KNEE_DOWN;
            hip_b <= HIP_FWD;    knee_b <= KNEE_DOWN;
          end
          default: begin
            // PARK: hips stay where they are, both groups stand.
            knee_a <= KNEE_DOWN;
            knee_b <= KNEE_DOWN;
          end
        endcase
      end
    end
  end

  assign gait.phase      = state;
  assign gait.hip_a      = hip_a;
  assign gait.knee_a     = knee_a;
  assign gait.hip_b      = hip_b;
  assign gait.knee_b     = knee_b;
  assign gait.homed      = homed;
  assign gait.cycle_done = cycle_done;

endmodule
